// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit CPU sequencer: state encoding,
// opcode values and instruction field positions.
package cpu_pkg;

  localparam int N     = 16;
  localparam int OP_W  = 4;
  localparam int REG_W = 4;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_AND  = 4'h2;
  localparam logic [OP_W-1:0] OP_OR   = 4'h3;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;
  // Opcode shown while no instruction is active; the operand demuxes decode it to zero.
  localparam logic [OP_W-1:0] OP_IDLE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    logic alu;
    alu = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: alu = 1'b1;
      default:                       alu = 1'b0;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/cpu_pc_reg.sv
// Program counter: async active-high reset to 0, +1 on inc_en, silent wrap.
// Latency: new value visible the cycle after inc_en; no backpressure.
module cpu_pc_reg #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_en,
  output logic [PC_W-1:0] pc_out
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (inc_en) pc_d = pc_q + PC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign pc_out = pc_q;

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/writeback sequencer; ALU op takes 4 cycles, NOP 2.
// FETCH stalls indefinitely until instr_valid; controls decode from state so reset kills strobes at once.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              instr_valid,
  input  logic [N-1:0]      instr_in,
  output logic              fetch_req,
  output logic [PC_W-1:0]   pc_out,
  output logic [OP_W-1:0]   op_code,
  output logic [REG_W-1:0]  rs1_addr,
  output logic [REG_W-1:0]  rs2_addr,
  output logic [REG_W-1:0]  rd_addr,
  output logic              alu_en,
  output logic              rf_we,
  output logic              busy,
  output logic              halted
);

  state_t       state_q, state_d;
  logic [N-1:0] ir_q, ir_d;
  logic         pc_inc;

  logic [OP_W-1:0]  ir_op;
  logic [REG_W-1:0] ir_rd, ir_rs1, ir_rs2;

  assign ir_op  = ir_q[OP_MSB:OP_LSB];
  assign ir_rd  = ir_q[RD_MSB:RD_LSB];
  assign ir_rs1 = ir_q[RS1_MSB:RS1_LSB];
  assign ir_rs2 = ir_q[RS2_MSB:RS2_LSB];

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_inc    = 1'b0;
    fetch_req = 1'b0;
    alu_en    = 1'b0;
    rf_we     = 1'b0;
    busy      = 1'b1;
    halted    = 1'b0;
    op_code   = OP_IDLE;
    rs1_addr  = '0;
    rs2_addr  = '0;
    rd_addr   = '0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) begin
          ir_d    = instr_in;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        op_code  = ir_op;
        rs1_addr = ir_rs1;
        rs2_addr = ir_rs2;
        rd_addr  = ir_rd;
        if (is_alu_op(ir_op)) begin
          state_d = ST_EXEC;
        end else if (ir_op == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          // Anything outside the ALU set and HALT retires here as a NOP.
          pc_inc  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        op_code  = ir_op;
        rs1_addr = ir_rs1;
        rs2_addr = ir_rs2;
        rd_addr  = ir_rd;
        alu_en   = 1'b1;
        state_d  = ST_WB;
      end
      ST_WB: begin
        op_code  = ir_op;
        rs1_addr = ir_rs1;
        rs2_addr = ir_rs2;
        rd_addr  = ir_rd;
        rf_we    = 1'b1;
        pc_inc   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  cpu_pc_reg #(
    .PC_W(PC_W)
  ) u_pc (
    .clk   (clk),
    .rst   (rst),
    .inc_en(pc_inc),
    .pc_out(pc_out)
  );

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: per-instruction expected-output schedule checked every cycle,
// plus literal pins on pulse timing, decoded fields and PC values.
module tb_cpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_in = 16'h0000;
  logic        fetch_req;
  logic [7:0]  pc_out;
  logic [3:0]  op_code, rs1_addr, rs2_addr, rd_addr;
  logic        alu_en, rf_we, busy, halted;

  cpu_seq_ctrl #(.PC_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .instr_valid(instr_valid),
    .instr_in   (instr_in),
    .fetch_req  (fetch_req),
    .pc_out     (pc_out),
    .op_code    (op_code),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_addr    (rd_addr),
    .alu_en     (alu_en),
    .rf_we      (rf_we),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       fr;
    logic [7:0] pc;
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       alu;
    logic       we;
    logic       busy;
    logic       halt;
  } obs_t;

  obs_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] m_pc = 8'h00;
  bit         m_halt = 1'b0;

  int         cyc_n = 0;
  int         alu_cnt = 0, we_cnt = 0, fr_cnt = 0;
  int         last_alu_cyc = 0, last_we_cyc = 0;
  logic [15:0] last_alu_fields = 16'h0000;
  logic [3:0]  last_we_rd = 4'h0;

  function automatic obs_t dut_obs();
    obs_t o;
    o = {fetch_req, pc_out, op_code, rd_addr, rs1_addr, rs2_addr, alu_en, rf_we, busy, halted};
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o    = '0;
    o.op = 4'hF;
    return o;
  endfunction

  // Outputs in IDLE or HALT: nothing active, opcode parked at F.
  function automatic obs_t quiet();
    obs_t o;
    o      = '0;
    o.op   = 4'hF;
    o.pc   = m_pc;
    o.halt = m_halt;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic st, input logic iv, input logic [15:0] ins, input obs_t e);
    start       = st;
    instr_valid = iv;
    instr_in    = ins;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_outputs", 32'(dut_obs()), 32'(reset_obs()));
    rst    = 1'b0;
    m_pc   = 8'h00;
    m_halt = 1'b0;
  endtask

  // One instruction from its first FETCH cycle to retirement.
  task automatic do_instr(input logic [15:0] w, input int delay, input bit noise, input bit abort);
    obs_t e, x;
    logic [3:0] op;
    int we_before;
    op = w[15:12];
    for (int i = 0; i <= delay; i++) begin
      e      = quiet();
      e.fr   = 1'b1;
      e.busy = 1'b1;
      e.halt = 1'b0;
      cyc(1'b0, i == delay, (i == delay) ? w : 16'h0000, e);
    end
    e      = quiet();
    e.busy = 1'b1;
    e.op   = op;
    e.rd   = w[11:8];
    e.rs1  = w[7:4];
    e.rs2  = w[3:0];
    cyc(1'b0, noise, 16'hFFFF, e);
    if (op <= 4'h3) begin
      x     = e;
      x.alu = 1'b1;
      cyc(1'b0, noise, 16'hFFFF, x);
      x    = e;
      x.we = 1'b1;
      if (!abort) begin
        cyc(1'b0, 1'b0, 16'h0000, x);
        m_pc = m_pc + 8'd1;
      end else begin
        start       = 1'b0;
        instr_valid = 1'b0;
        we_before   = we_cnt;
        check("wb_rf_we_before_rst", 32'(rf_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rf_we_drop", 32'(rf_we), 32'd0);
        check("async_alu_en_low", 32'(alu_en), 32'd0);
        check("async_op_code", 32'(op_code), 32'hF);
        check("async_pc_zero", 32'(pc_out), 32'd0);
        check("async_busy_low", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("async_reset_outputs", 32'(dut_obs()), 32'(reset_obs()));
        check("no_partial_wb", 32'(we_cnt), 32'(we_before));
        rst    = 1'b0;
        m_pc   = 8'h00;
        m_halt = 1'b0;
      end
    end else if (op == 4'hF) begin
      m_halt = 1'b1;
    end else begin
      m_pc = m_pc + 8'd1;
    end
  endtask

  always @(posedge clk) cyc_n++;

  // Compare process: checks DUT against the schedule and tallies strobe events.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle_outputs", 32'(dut_obs()), 32'(e));
      end
      if (fetch_req) fr_cnt++;
      if (alu_en) begin
        alu_cnt++;
        last_alu_cyc    = cyc_n;
        last_alu_fields = {op_code, rd_addr, rs1_addr, rs2_addr};
      end
      if (rf_we) begin
        we_cnt++;
        last_we_cyc = cyc_n;
        last_we_rd  = rd_addr;
      end
    end
  end

  initial begin
    int s;
    logic [15:0] w;
    @(posedge clk);
    #1;
    check("reset_outputs_init", 32'(dut_obs()), 32'(reset_obs()));
    rst = 1'b0;

    // 1: ALU op returned on the first FETCH cycle
    s = cyc_n;
    cyc(1'b1, 1'b0, 16'h0000, quiet());
    do_instr(16'h0123, 0, 1'b0, 1'b0);
    check("t1_alu_cycle", 32'(last_alu_cyc - s), 32'd3);
    check("t1_we_cycle", 32'(last_we_cyc - s), 32'd4);
    check("t1_fields", 32'(last_alu_fields), 32'h0123);
    check("t1_pc_after_wb", 32'(pc_out), 32'd1);
    check("t1_refetch", 32'(fetch_req), 32'd1);

    // 2: memory stalls 5 cycles; stray instr_valid during DECODE/EXEC
    fr_cnt = 0;
    do_instr(16'h2abc, 5, 1'b1, 1'b0);
    check("t2_fetch_cycles", 32'(fr_cnt), 32'd6);
    check("t2_fields", 32'(last_alu_fields), 32'h2abc);
    check("t2_pc", 32'(pc_out), 32'd2);

    // 3: ALU, NOP, HALT; start pulses in HALT are ignored
    do_reset();
    cyc(1'b1, 1'b0, 16'h0000, quiet());
    we_cnt = 0;
    do_instr(16'h3456, 0, 1'b0, 1'b0);
    do_instr(16'h7000, 0, 1'b0, 1'b0);
    do_instr(16'hF000, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(i[0], 1'b0, 16'h0000, quiet());
    check("t3_we_pulses", 32'(we_cnt), 32'd1);
    check("t3_we_rd", 32'(last_we_rd), 32'd4);
    check("t3_pc", 32'(pc_out), 32'd2);
    check("t3_halted", 32'(halted), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);

    // 4: 255 NOPs then an ALU op wraps the PC
    do_reset();
    cyc(1'b1, 1'b0, 16'h0000, quiet());
    for (int i = 0; i < 255; i++) begin
      w = {4'(4 + (i % 11)), 12'(i * 7)};
      do_instr(w, 0, 1'b0, 1'b0);
    end
    check("t4_pc_255", 32'(pc_out), 32'd255);
    do_instr(16'h0abc, 0, 1'b0, 1'b0);
    check("t4_pc_wrap", 32'(pc_out), 32'd0);

    // 5: async reset in the middle of WB
    do_instr(16'h1def, 0, 1'b0, 1'b0);
    check("t5_pc_before", 32'(pc_out), 32'd1);
    do_instr(16'h2345, 0, 1'b0, 1'b1);

    // 6: idle with start low
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 16'h0000, quiet());
    check("t6_idle_outputs", 32'(dut_obs()), 32'(reset_obs()));

    @(negedge clk);
    #1;
    check("schedule_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Multi-cycle control FSM for the 16-bit CPU datapath. Sequences one instruction at a time: fetch, decode, ALU execute, writeback. Drives the opcode seen by the operand demuxes (rs1/rs2 select) and ALU, the register-file read/write addresses and the write enable. Owns the program counter.

Parameters:
N, 16, datapath/instruction width
PC_W, 8, program counter width
OP_W, 4, opcode field width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin execution from PC 0 (sampled in IDLE only)
instr_valid  input  1  instruction memory returns instr_in this cycle
instr_in  input  N  instruction word: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2
fetch_req  output  1  request instruction at pc_out
pc_out  output  PC_W  current program counter
op_code  output  OP_W  opcode to operand demuxes and ALU
rs1_addr  output  4  register-file read address A
rs2_addr  output  4  register-file read address B
rd_addr  output  4  register-file write address
alu_en  output  1  ALU evaluate/capture strobe
rf_we  output  1  register-file write enable
busy  output  1  high in any state except IDLE and HALT
halted  output  1  HALT instruction retired

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. rst forces state IDLE immediately, independent of clk.
- Reset values: pc_out=0, instruction register=0, fetch_req=0, alu_en=0, rf_we=0, busy=0, halted=0, op_code=4'hF, all addresses=0.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: start=1 -> FETCH. Otherwise stay.
- FETCH: fetch_req=1 every cycle until instr_valid=1. On that edge latch instr_in -> DECODE. No timeout. instr_valid outside FETCH is ignored.
- DECODE: one cycle. Drive op_code, rs1_addr, rs2_addr, rd_addr from the latched word.
  - op 0000..0011 (ALU ops) -> EXEC.
  - op 1111 (HALT) -> HALT.
  - Any other op is a NOP: pc+1 -> FETCH, with no alu_en and no rf_we.
- EXEC: alu_en=1 for exactly one cycle -> WB.
- WB: rf_we=1 for exactly one cycle with rd_addr stable. pc+1 -> FETCH.
- HALT: halted=1 and busy=0, held until rst. start is ignored.
- op_code and addresses hold the latched fields in DECODE, EXEC and WB. In IDLE, FETCH and HALT, op_code=4'hF, so the operand demuxes output 0.
- Latency: an ALU instruction with instr_valid on the first FETCH cycle takes 4 cycles (FETCH, DECODE, EXEC, WB), and the next fetch_req comes in cycle 5. A NOP takes 2 cycles.
- PC arithmetic: unsigned PC_W-bit. Increments only on WB exit or NOP DECODE exit. 2^PC_W-1 wraps to 0 with no flag.
- rst mid-instruction: rf_we and alu_en drop asynchronously and no partial writeback occurs. The PC returns to 0.
- start held high continuously has no effect outside IDLE.

Decomposition:
- Package cpu_pkg holds:
  - state enum (IDLE..HALT)
  - opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_HALT=4'hF, OP_IDLE=4'hF
  - instruction field bit positions
  - localparams N and OP_W
- One sub-module, cpu_pc_reg: PC register with async reset, increment enable and wrap.
- The FSM and output decode stay in cpu_seq_ctrl.

Test Plan:
1. Reset then start; instr 16'h0123 returned on the first FETCH cycle -> DECODE shows op_code=0, rd=1, rs1=2, rs2=3; alu_en pulses in cycle 3, rf_we in cycle 4; pc_out goes 0->1 after WB.
2. instr_valid delayed 5 cycles -> fetch_req held high 6 cycles; pc_out unchanged throughout; no alu_en or rf_we.
3. Sequence 16'h3456, 16'h7000 (NOP), 16'hF000 -> one rf_we pulse (rd=4); pc reaches 2; halted=1, busy=0; a later start pulse is ignored.
4. Preload PC=255 (run 255 NOPs) then execute an ALU op -> pc_out wraps to 0 after WB.
5. Assert rst asynchronously (mid-cycle) during WB -> rf_we drops before the next clk edge; state IDLE; pc_out=0; op_code=4'hF.
6. Idle with start=0 for 20 cycles -> fetch_req=0, busy=0, all outputs at reset values.
